instruction_fetch_stage: RTL

Fetch front end of the five-stage RISC-V core. It owns the program counter and drives the word-aligned instruction-memory request. It captures returned instructions into the IF/ID pipeline register that feeds the decode stage as `instr_i[31:2]` / `pc_i[31:2]`. It honours the decode stage's load-use `stall`, redirects on taken branches/jumps, and raises `busywait` to freeze the rest of the pipeline while memory is pending.

---
 rtl/instruction_fetch_stage.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: owns the PC, drives instruction-memory requests and the IF/ID register.
// Optional one-entry skid buffer for acks that arrive during a stall: define FETCH_BUF_EN.
module instruction_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [29:0] target_i,
    output logic        imem_req_o,
    output logic [29:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic        busywait_o,
    output logic [29:0] instr_if_id_o,
    output logic [29:0] pc_if_id_o,
    output logic        valid_if_id_o
);

    localparam logic [29:0] RESET_WORD = RESET_PC[31:2];
    localparam logic [29:0] NOP_WORD   = NOP_INSTR[31:2];

    typedef enum logic [1:0] {
        S_BOOT,
        S_FETCH
`ifdef FETCH_BUF_EN
        ,
        S_HOLD
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [29:0] pc_q, pc_d;
    logic [29:0] instr_q, instr_d;
    logic [29:0] ifpc_q, ifpc_d;
    logic        valid_q, valid_d;
    logic        hold;

    // Opcode bits [1:0] are always 2'b11 and are not stored.
    logic        unused_rdata_bits;
    assign unused_rdata_bits = ^imem_rdata_i[1:0];

`ifdef FETCH_BUF_EN
    logic [29:0] buf_instr_q, buf_instr_d;
    logic [29:0] buf_pc_q, buf_pc_d;

    assign hold = (state_q == S_HOLD);
`else
    assign hold = 1'b0;
`endif

    assign imem_req_o    = (state_q != S_BOOT);
    assign imem_addr_o   = pc_q;
    // While holding, IF/ID is fed from the buffer, so memory is never waited on.
    assign busywait_o    = imem_req_o & ~imem_ack_i & ~hold;
    assign instr_if_id_o = instr_q;
    assign pc_if_id_o    = ifpc_q;
    assign valid_if_id_o = valid_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        ifpc_d  = ifpc_q;
        valid_d = valid_q;
`ifdef FETCH_BUF_EN
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
`endif
        if (state_q == S_BOOT) begin
            state_d = S_FETCH;
        end else if (flush_i) begin
            state_d = S_FETCH;
            pc_d    = target_i;
            instr_d = NOP_WORD;
            ifpc_d  = target_i;
            valid_d = 1'b0;
`ifdef FETCH_BUF_EN
            buf_instr_d = NOP_WORD;
            buf_pc_d    = target_i;
`endif
        end else begin
            unique case (state_q)
                S_FETCH: begin
                    if (stall_i) begin
`ifdef FETCH_BUF_EN
                        if (imem_ack_i) begin
                            buf_instr_d = imem_rdata_i[31:2];
                            buf_pc_d    = pc_q;
                            pc_d        = pc_q + 30'd1;
                            state_d     = S_HOLD;
                        end
`endif
                    end else if (imem_ack_i) begin
                        instr_d = imem_rdata_i[31:2];
                        ifpc_d  = pc_q;
                        valid_d = 1'b1;
                        pc_d    = pc_q + 30'd1;
                    end
                end
`ifdef FETCH_BUF_EN
                S_HOLD: begin
                    // Any ack here is dropped; PC still names that word.
                    if (!stall_i) begin
                        instr_d = buf_instr_q;
                        ifpc_d  = buf_pc_q;
                        valid_d = 1'b1;
                        state_d = S_FETCH;
                    end
                end
`endif
                default: begin
                    state_d = S_BOOT;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_BOOT;
            pc_q    <= RESET_WORD;
            instr_q <= NOP_WORD;
            ifpc_q  <= RESET_WORD;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ifpc_q  <= ifpc_d;
            valid_q <= valid_d;
        end
    end

`ifdef FETCH_BUF_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            buf_instr_q <= NOP_WORD;
            buf_pc_q    <= RESET_WORD;
        end else begin
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
        end
    end
`endif

endmodule
